vga_rgb_fifo: RTL and testbench
===============================

// Module: vga_rgb_fifo
// PURPOSE
//  Pixel FIFO between vga_colproc (writer) and the pixel output/timing stage (reader).
//  - Absorbs the bursty, per-ColorDepth pixel stream produced by colproc.
//  - Delivers one RGB word per read request.
//  - Full and nearly_full give colproc backpressure (rgb_fifo_full).
//  - Sticky overflow/underflow flags report protocol errors to the status register.
// PARAMETERS
//  DW      24  pixel word width (8:8:8 RGB)
//  AW      4   address width; DEPTH = 2**AW = 16 entries
//  AFULL   2   nearly_full asserts when level >= DEPTH-AFULL
// PORTS
//  clk          in   1      system clock; all logic on posedge
//  rst          in   1      asynchronous reset, active-high
//  srst         in   1      synchronous clear, active-high (frame restart / ctrl disable)
//  wreq         in   1      write request (rgb_fifo_wreq from colproc)
//  d            in   DW     write data
//  rreq         in   1      read request from pixel stage
//  q            out  DW     read data, registered
//  empty        out  1      no stored entries
//  full         out  1      level == DEPTH (rgb_fifo_full to colproc)
//  nearly_full  out  1      level >= DEPTH-AFULL
//  level        out  AW+1   current entry count, 0..DEPTH
//  ovf          out  1      sticky: write attempted while full
//  unf          out  1      sticky: read attempted while empty
//  err_clr      in   1      clears ovf/unf (write-1-clear from status reg)
// BEHAVIOUR
//  Reset (rst, async):
//   - wptr=rptr=0, level=0, q=0, ovf=unf=0.
//   - empty=1, full=0, nearly_full=0.
//   - Memory contents are not reset.
//  srst (sync):
//   - Same values as rst, applied at the next posedge.
//   - Overrides wreq, rreq and err_clr in the same cycle.
//   - Mid-burst srst discards all stored data; no partial word remains.
//  Write:
//   - wreq & !full: mem[wptr] <= d, wptr+1, modulo DEPTH (natural AW-bit wrap).
//   - wreq & full: ignored, ovf <= 1. Pointers and level are unchanged.
//  Read:
//   - rreq & !empty: q <= mem[rptr] at that posedge, rptr+1 with wrap.
//   - Latency is 1: data is valid on q in the cycle after the accepted request.
//   - q holds its value until the next accepted read.
//   - rreq & empty: ignored, unf <= 1, q holds.
//  Simultaneous wreq & rreq (legality judged on pre-edge state):
//   - Neither full nor empty: both accepted, level unchanged.
//   - Empty: write accepted, read rejected (unf <= 1), level 0->1.
//     Read-through of same-cycle data is not supported.
//   - Full: read accepted, write rejected (ovf <= 1), level DEPTH->DEPTH-1.
//  Level and flags:
//   - level = +1 on write only, -1 on read only, 0 otherwise. Never exceeds DEPTH, never below 0.
//   - empty, full and nearly_full are registered, derived from next-state level.
//     They change in the same cycle as level; no combinational path from wreq/rreq.
//  Sticky flags:
//   - err_clr clears ovf/unf.
//   - A new error in the same cycle as err_clr wins: the flag stays 1.
//  Pointer bookkeeping:
//   - Count-based: level register, not an extra pointer MSB.
//   - wptr == rptr is unambiguous via level.
// STRUCTURE
//  Package vga_pkg (shared):
//   - RGB_W=24.
//   - typedef logic [RGB_W-1:0] rgb_t.
//   - RGB_FIFO_AW=4.
//  Sub-module vga_fifo_dpram:
//   - Simple dual-port, 1W/1R, registered read port.
//   - Replaceable by a vendor macro.
//  Top level holds pointers, level counter, flags and control.
// TESTING
//  1 Reset:
//    - rst pulse mid-operation with 5 entries stored -> immediately level=0, empty=1, q=0, ovf=unf=0.
//    - A following read -> unf=1.
//  2 Fill/drain:
//    - 16 writes d=0x000001..0x000010 -> full=1 after the 16th, nearly_full from level 14.
//    - 16 reads -> q = 0x000001..0x000010 in order, each one cycle after its rreq, then empty=1.
//  3 Overflow:
//    - Write 0xABCDEF while full -> ovf=1, level stays 16.
//    - Drain -> 0xABCDEF never appears.
//    - err_clr -> ovf=0.
//  4 Simultaneous:
//    - wreq & rreq at level 0 -> level 1, unf=1.
//    - At level 16 -> level 15, ovf=1.
//    - At level 8, 20 cycles continuous -> level stays 8 and data order is preserved across pointer wrap.
//  5 srst with err_clr and wreq in the same cycle, at level 9 -> level=0, flags 0, write discarded.
//  6 Random colproc-style bursts gated by full, reader at 1/2 rate, against a scoreboard -> no ovf, no data loss.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and sizes.
package vga_pkg;

  localparam int unsigned RGB_W       = 24;
  localparam int unsigned RGB_FIFO_AW = 4;

  typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/vga_fifo_dpram.sv
// Simple dual-port RAM, one write and one registered read port.
// Only the read register is cleared; the array itself holds whatever was written.
module vga_fifo_dpram #(
  parameter int unsigned DW = 24,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (re)  q <= mem[raddr];
  end

endmodule

// File: rtl/vga_rgb_fifo.sv
// Pixel FIFO between colour processing and the pixel output stage.
// Count-based occupancy; status flags are registered from the next-state level.
module vga_rgb_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DW    = RGB_W,
  parameter int unsigned AW    = RGB_FIFO_AW,
  parameter int unsigned AFULL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          srst,
  input  logic          wreq,
  input  logic [DW-1:0] d,
  input  logic          rreq,
  output logic [DW-1:0] q,
  output logic          empty,
  output logic          full,
  output logic          nearly_full,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          unf,
  input  logic          err_clr
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = AW + 1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_ok;
  logic          rd_ok;
  logic [AW:0]   lvl_nxt;

  // Legality is judged on the registered flags, so no wreq/rreq -> flag path exists.
  always_comb begin
    wr_ok   = wreq & ~full;
    rd_ok   = rreq & ~empty;
    lvl_nxt = level + LW'(wr_ok) - LW'(rd_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      nearly_full <= 1'b0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
    end else if (srst) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      nearly_full <= 1'b0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      level       <= lvl_nxt;
      empty       <= (lvl_nxt == '0);
      full        <= (lvl_nxt == LW'(DEPTH));
      nearly_full <= (lvl_nxt >= LW'(DEPTH - AFULL));
      // A fresh error in the clearing cycle keeps the flag set.
      ovf         <= (wreq & full)  | (ovf & ~err_clr);
      unf         <= (rreq & empty) | (unf & ~err_clr);
    end
  end

  vga_fifo_dpram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .clr   (srst),
    .we    (wr_ok & ~srst),
    .waddr (wptr),
    .wdata (d),
    .re    (rd_ok & ~srst),
    .raddr (rptr),
    .q     (q)
  );

endmodule

// File: tb/tb_vga_rgb_fifo.sv
// Directed and scoreboarded checks for vga_rgb_fifo.
module tb_vga_rgb_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        srst;
  logic        wreq;
  logic [23:0] d;
  logic        rreq;
  logic [23:0] q;
  logic        empty;
  logic        full;
  logic        nearly_full;
  logic [4:0]  level;
  logic        ovf;
  logic        unf;
  logic        err_clr;

  int total = 0;
  int bad   = 0;

  logic [23:0] sb [$];

  vga_rgb_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .srst        (srst),
    .wreq        (wreq),
    .d           (d),
    .rreq        (rreq),
    .q           (q),
    .empty       (empty),
    .full        (full),
    .nearly_full (nearly_full),
    .level       (level),
    .ovf         (ovf),
    .unf         (unf),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [23:0] val);
    wreq = 1'b1;
    d    = val;
    tick();
    wreq = 1'b0;
  endtask

  task automatic rd();
    rreq = 1'b1;
    tick();
    rreq = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; srst = 1'b0; wreq = 1'b0; rreq = 1'b0; d = '0; err_clr = 1'b0;
    tick(); tick();
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_nf", 32'(nearly_full), 0);
    check("rst_q", 32'(q), 0);
    check("rst_flags", {30'd0, ovf, unf}, 0);
    rst = 1'b0;
    tick();

    // 1: async reset with 5 entries stored
    for (int i = 1; i <= 6; i++) wr(24'(32'hA0 + i));
    rd();
    check("t1_q_pre", 32'(q), 32'hA1);
    check("t1_lvl_pre", 32'(level), 5);
    #3 rst = 1'b1;
    #1;
    check("t1_async_level", 32'(level), 0);
    check("t1_async_empty", 32'(empty), 1);
    check("t1_async_q", 32'(q), 0);
    check("t1_async_flags", {30'd0, ovf, unf}, 0);
    tick();
    rst = 1'b0;
    rd();
    check("t1_unf", 32'(unf), 1);
    check("t1_q_hold", 32'(q), 0);
    clr_err();
    check("t1_unf_clr", 32'(unf), 0);

    // 2: fill and drain
    for (int i = 1; i <= 16; i++) begin
      wr(24'(i));
      check("t2_fill_level", 32'(level), 32'(i));
      check("t2_fill_nf", 32'(nearly_full), 32'(i >= 14));
      check("t2_fill_full", 32'(full), 32'(i == 16));
      check("t2_fill_empty", 32'(empty), 0);
    end
    for (int i = 1; i <= 16; i++) begin
      rd();
      check("t2_drain_q", 32'(q), 32'(i));
      check("t2_drain_level", 32'(level), 32'(16 - i));
    end
    check("t2_empty", 32'(empty), 1);
    check("t2_flags", {30'd0, ovf, unf}, 0);

    // 3: overflow
    for (int i = 1; i <= 16; i++) wr(24'(32'h100 + i));
    wr(24'hABCDEF);
    check("t3_ovf", 32'(ovf), 1);
    check("t3_level", 32'(level), 16);
    check("t3_full", 32'(full), 1);
    for (int i = 1; i <= 16; i++) begin
      rd();
      check("t3_drain_q", 32'(q), 32'(32'h100 + i));
    end
    check("t3_empty", 32'(empty), 1);
    clr_err();
    check("t3_ovf_clr", 32'(ovf), 0);

    // 4a: simultaneous at empty
    wreq = 1'b1; rreq = 1'b1; d = 24'h000055;
    tick();
    wreq = 1'b0; rreq = 1'b0;
    check("t4a_level", 32'(level), 1);
    check("t4a_unf", 32'(unf), 1);
    check("t4a_q_hold", 32'(q), 32'h110);
    rd();
    check("t4a_q", 32'(q), 32'h55);
    clr_err();

    // 4b: simultaneous at full
    for (int i = 1; i <= 16; i++) wr(24'(32'h200 + i));
    wreq = 1'b1; rreq = 1'b1; d = 24'h00DEAD;
    tick();
    wreq = 1'b0; rreq = 1'b0;
    check("t4b_level", 32'(level), 15);
    check("t4b_ovf", 32'(ovf), 1);
    check("t4b_q", 32'(q), 32'h201);
    check("t4b_full", 32'(full), 0);
    for (int i = 2; i <= 16; i++) begin
      rd();
      check("t4b_drain_q", 32'(q), 32'(32'h200 + i));
    end
    check("t4b_empty", 32'(empty), 1);
    clr_err();
    check("t4b_ovf_clr", 32'(ovf), 0);

    // 4c: level 8, 20 continuous read+write cycles across pointer wrap
    for (int i = 0; i < 8; i++) begin
      wr(24'(32'h300 + i));
      sb.push_back(24'(32'h300 + i));
    end
    for (int k = 0; k < 20; k++) begin
      wreq = 1'b1; rreq = 1'b1; d = 24'(32'h400 + k);
      tick();
      check("t4c_q", 32'(q), 32'(sb.pop_front()));
      sb.push_back(24'(32'h400 + k));
      check("t4c_level", 32'(level), 8);
    end
    wreq = 1'b0; rreq = 1'b0;
    while (sb.size() > 0) begin
      rd();
      check("t4c_drain_q", 32'(q), 32'(sb.pop_front()));
    end
    check("t4c_empty", 32'(empty), 1);
    check("t4c_flags", {30'd0, ovf, unf}, 0);

    // 5: srst beats err_clr and wreq at level 9
    rd();
    check("t5_unf_pre", 32'(unf), 1);
    for (int i = 0; i < 9; i++) wr(24'(32'h500 + i));
    check("t5_level_pre", 32'(level), 9);
    srst = 1'b1; err_clr = 1'b1; wreq = 1'b1; d = 24'h000777;
    tick();
    srst = 1'b0; err_clr = 1'b0; wreq = 1'b0;
    check("t5_level", 32'(level), 0);
    check("t5_empty", 32'(empty), 1);
    check("t5_flags", {30'd0, ovf, unf}, 0);
    check("t5_q", 32'(q), 0);
    rd();
    check("t5_discard_unf", 32'(unf), 1);
    check("t5_discard_level", 32'(level), 0);
    clr_err();

    // 6: bursty writer gated by full, half-rate reader, scoreboard
    begin
      int burst;
      logic wa, ra;
      logic [23:0] dv;
      burst = 0;
      for (int c = 0; c < 600; c++) begin
        if (burst == 0 && $urandom_range(0, 3) == 0) burst = int'($urandom_range(4, 24));
        wreq = (burst > 0) && !full;
        rreq = (c % 2 == 0) && (sb.size() > 0);
        dv   = 24'($urandom);
        d    = dv;
        wa   = wreq && (sb.size() < 16);
        ra   = rreq && (sb.size() > 0);
        tick();
        if (ra) check("t6_q", 32'(q), 32'(sb.pop_front()));
        if (wa) sb.push_back(dv);
        check("t6_level", 32'(level), 32'(sb.size()));
        if (burst > 0) burst--;
      end
      wreq = 1'b0; rreq = 1'b0;
      check("t6_ovf", 32'(ovf), 0);
      check("t6_unf", 32'(unf), 0);
      while (sb.size() > 0) begin
        rd();
        check("t6_drain_q", 32'(q), 32'(sb.pop_front()));
      end
      check("t6_empty", 32'(empty), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
